// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the register file and the ALU units.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int BYTE_W     = 8;
    localparam int ZERO_REG   = 0;

    // Size of the full register address space (every 5-bit address)
    localparam int NUM_ADDR   = 1 << REG_ADDR_W;

    // Number of byte lanes in a data word of the given width
    function automatic int num_bytes(input int width);
        return width / BYTE_W;
    endfunction

endpackage : cpu_pkg

// File: rtl/reg_file_byte_merge.sv
// Byte-lane merge: takes each byte from new_data where be is set, else from old_data.
module byte_merge
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic [XLEN-1:0]                  old_data,
    input  logic [XLEN-1:0]                  new_data,
    input  logic [cpu_pkg::num_bytes(XLEN)-1:0] be,
    output logic [XLEN-1:0]                  merged
);

    localparam int NBYTES = cpu_pkg::num_bytes(XLEN);

    // Select every byte lane independently from the old or the new word
    always_comb begin
        merged = old_data;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                merged[b*BYTE_W +: BYTE_W] = new_data[b*BYTE_W +: BYTE_W];
            end else begin
                merged[b*BYTE_W +: BYTE_W] = old_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule : byte_merge

// File: rtl/reg_file.sv
// Architectural register file: two bypassed operand read ports, one raw debug
// read port and one byte-enabled write port. Register 0 is hardwired to zero.
module reg_file
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REG_ADDR_W-1:0]            Rs1_addr,
    input  logic [REG_ADDR_W-1:0]            Rs2_addr,
    input  logic [REG_ADDR_W-1:0]            Dbg_addr,
    input  logic                             Wr_en,
    input  logic [REG_ADDR_W-1:0]            Wr_addr,
    input  logic [cpu_pkg::num_bytes(XLEN)-1:0] Wr_be,
    input  logic [XLEN-1:0]                  Wr_data,
    output logic [XLEN-1:0]                  ALU_DA,
    output logic [XLEN-1:0]                  ALU_DB,
    output logic [XLEN-1:0]                  Dbg_data
);

    // Storage spans the whole address space; entries that are register 0 or
    // beyond NREGS are forced to zero so they read 0 and never take writes.
    logic [XLEN-1:0] regs_q [NUM_ADDR];
    logic [XLEN-1:0] regs_d [NUM_ADDR];

    logic            wr_in_range_s;
    logic            wr_valid_s;
    logic [XLEN-1:0] wr_old_s;
    logic [XLEN-1:0] wr_merged_s;
    logic [XLEN-1:0] rs1_old_s;
    logic [XLEN-1:0] rs2_old_s;
    logic [XLEN-1:0] rs1_merged_s;
    logic [XLEN-1:0] rs2_merged_s;

    assign wr_in_range_s = (32'(Wr_addr) < 32'(NREGS));
    assign wr_valid_s    = Wr_en && (Wr_addr != REG_ADDR_W'(ZERO_REG)) && wr_in_range_s;
    assign wr_old_s      = regs_q[Wr_addr];
    assign rs1_old_s     = regs_q[Rs1_addr];
    assign rs2_old_s     = regs_q[Rs2_addr];

    byte_merge #(.XLEN(XLEN)) u_wr_merge (
        .old_data (wr_old_s),
        .new_data (Wr_data),
        .be       (Wr_be),
        .merged   (wr_merged_s)
    );

    byte_merge #(.XLEN(XLEN)) u_rs1_merge (
        .old_data (rs1_old_s),
        .new_data (Wr_data),
        .be       (Wr_be),
        .merged   (rs1_merged_s)
    );

    byte_merge #(.XLEN(XLEN)) u_rs2_merge (
        .old_data (rs2_old_s),
        .new_data (Wr_data),
        .be       (Wr_be),
        .merged   (rs2_merged_s)
    );

    // Next-state of the array: only the addressed, writable register changes
    always_comb begin
        for (int i = 0; i < NUM_ADDR; i++) begin
            if ((i == ZERO_REG) || (i >= NREGS)) begin
                regs_d[i] = '0;
            end else if (wr_valid_s && (Wr_addr == REG_ADDR_W'(i))) begin
                regs_d[i] = wr_merged_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage flops, cleared asynchronously so a write at a reset edge is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ADDR; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ADDR; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: operands see the post-edge value on a write hit, debug does not
    always_comb begin
        ALU_DA   = '0;
        ALU_DB   = '0;
        Dbg_data = '0;
        if (!rst_n) begin
            ALU_DA   = '0;
            ALU_DB   = '0;
            Dbg_data = '0;
        end else begin
            if (wr_valid_s && (Wr_addr == Rs1_addr)) begin
                ALU_DA = rs1_merged_s;
            end else begin
                ALU_DA = rs1_old_s;
            end
            if (wr_valid_s && (Wr_addr == Rs2_addr)) begin
                ALU_DB = rs2_merged_s;
            end else begin
                ALU_DB = rs2_old_s;
            end
            Dbg_data = regs_q[Dbg_addr];
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1_addr;
    logic [4:0]  Rs2_addr;
    logic [4:0]  Dbg_addr;
    logic        Wr_en;
    logic [4:0]  Wr_addr;
    logic [3:0]  Wr_be;
    logic [31:0] Wr_data;
    logic [31:0] ALU_DA;
    logic [31:0] ALU_DB;
    logic [31:0] Dbg_data;

    int err_cnt;
    int chk_cnt;

    reg_file #(.XLEN(32), .NREGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Rs1_addr (Rs1_addr),
        .Rs2_addr (Rs2_addr),
        .Dbg_addr (Dbg_addr),
        .Wr_en    (Wr_en),
        .Wr_addr  (Wr_addr),
        .Wr_be    (Wr_be),
        .Wr_data  (Wr_data),
        .ALU_DA   (ALU_DA),
        .ALU_DB   (ALU_DB),
        .Dbg_data (Dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        Rs1_addr = a;
        Rs2_addr = b;
        Dbg_addr = d;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] addr, input logic [3:0] be,
                          input logic [31:0] data);
        Wr_en   = en;
        Wr_addr = addr;
        Wr_be   = be;
        Wr_data = data;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst_n   = 1'b0;
        set_rd(5'd0, 5'd0, 5'd0);
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Every address reads zero on every port after reset
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(i), 5'(i));
            #1;
            check_val($sformatf("rst_da_%0d", i), ALU_DA, 32'h0000_0000);
            check_val($sformatf("rst_db_%0d", i), ALU_DB, 32'h0000_0000);
            check_val($sformatf("rst_dbg_%0d", i), Dbg_data, 32'h0000_0000);
        end

        // Full write of x5, read back next cycle
        set_rd(5'd0, 5'd0, 5'd0);
        set_wr(1'b1, 5'd5, 4'b1111, 32'hDEAD_BEEF);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        set_rd(5'd5, 5'd0, 5'd5);
        #1;
        check_val("x5_da", ALU_DA, 32'hDEAD_BEEF);
        check_val("x5_dbg", Dbg_data, 32'hDEAD_BEEF);

        // Write to x0 is neither bypassed nor stored
        set_rd(5'd0, 5'd0, 5'd0);
        set_wr(1'b1, 5'd0, 4'b1111, 32'hFFFF_FFFF);
        #1;
        check_val("x0_byp_da", ALU_DA, 32'h0000_0000);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        #1;
        check_val("x0_da", ALU_DA, 32'h0000_0000);
        check_val("x0_dbg", Dbg_data, 32'h0000_0000);

        // Partial write with bypass on both operand ports, debug unbypassed
        set_rd(5'd5, 5'd5, 5'd5);
        set_wr(1'b1, 5'd5, 4'b0101, 32'h1122_3344);
        #1;
        check_val("pw_byp_da", ALU_DA, 32'hDE22_BE44);
        check_val("pw_byp_db", ALU_DB, 32'hDE22_BE44);
        check_val("pw_dbg_pre", Dbg_data, 32'hDEAD_BEEF);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        #1;
        check_val("pw_dbg_post", Dbg_data, 32'hDE22_BE44);

        // Bypass on one port only: the other reads stored data
        set_rd(5'd5, 5'd0, 5'd5);
        set_wr(1'b1, 5'd5, 4'b1000, 32'h7700_0000);
        #1;
        check_val("one_port_da", ALU_DA, 32'h7722_BE44);
        check_val("one_port_db", ALU_DB, 32'h0000_0000);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        #1;
        check_val("one_port_dbg", Dbg_data, 32'h7722_BE44);

        // Zero byte enables leave x7 alone and the bypass shows stored data
        set_wr(1'b1, 5'd7, 4'b1111, 32'h0123_4567);
        tick();
        set_rd(5'd7, 5'd7, 5'd7);
        set_wr(1'b1, 5'd7, 4'b0000, 32'hFFFF_FFFF);
        #1;
        check_val("be0_byp_da", ALU_DA, 32'h0123_4567);
        check_val("be0_byp_db", ALU_DB, 32'h0123_4567);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        #1;
        check_val("be0_dbg", Dbg_data, 32'h0123_4567);

        // Wr_en low with matching address: no bypass, no store
        set_wr(1'b0, 5'd7, 4'b1111, 32'hFFFF_FFFF);
        #1;
        check_val("nowr_da", ALU_DA, 32'h0123_4567);
        tick();
        check_val("nowr_dbg", Dbg_data, 32'h0123_4567);

        // Back-to-back writes to x9
        set_rd(5'd9, 5'd9, 5'd9);
        set_wr(1'b1, 5'd9, 4'b1111, 32'hAAAA_AAAA);
        #1;
        check_val("b2b_byp1", ALU_DA, 32'hAAAA_AAAA);
        tick();
        set_wr(1'b1, 5'd9, 4'b0001, 32'h0000_00BB);
        #1;
        check_val("b2b_byp2_da", ALU_DA, 32'hAAAA_AABB);
        check_val("b2b_byp2_db", ALU_DB, 32'hAAAA_AABB);
        check_val("b2b_dbg_mid", Dbg_data, 32'hAAAA_AAAA);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        #1;
        check_val("b2b_dbg_post", Dbg_data, 32'hAAAA_AABB);

        // Reset mid-cycle with a pending write to x3
        set_wr(1'b1, 5'd3, 4'b1111, 32'h1234_5678);
        tick();
        set_rd(5'd3, 5'd3, 5'd3);
        set_wr(1'b1, 5'd3, 4'b1111, 32'hCAFE_BABE);
        #1;
        check_val("pre_rst_da", ALU_DA, 32'hCAFE_BABE);
        check_val("pre_rst_dbg", Dbg_data, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        check_val("in_rst_da", ALU_DA, 32'h0000_0000);
        check_val("in_rst_db", ALU_DB, 32'h0000_0000);
        check_val("in_rst_dbg", Dbg_data, 32'h0000_0000);
        tick();
        check_val("rst_edge_da", ALU_DA, 32'h0000_0000);
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("post_rst_x3", Dbg_data, 32'h0000_0000);
        check_val("post_rst_da", ALU_DA, 32'h0000_0000);
        set_rd(5'd5, 5'd9, 5'd7);
        #1;
        check_val("post_rst_x5", ALU_DA, 32'h0000_0000);
        check_val("post_rst_x9", ALU_DB, 32'h0000_0000);
        check_val("post_rst_x7", Dbg_data, 32'h0000_0000);

        // First write after release is accepted
        set_wr(1'b1, 5'd31, 4'b0011, 32'h5555_1234);
        tick();
        set_wr(1'b0, 5'd0, 4'b0000, 32'h0000_0000);
        set_rd(5'd31, 5'd0, 5'd31);
        #1;
        check_val("x31_da", ALU_DA, 32'h0000_1234);
        check_val("x31_dbg", Dbg_data, 32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all writes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port Rs1_addr, input, 5, meaning read address for operand A.
REQ-006 SHALL have port Rs2_addr, input, 5, meaning read address for operand B.
REQ-007 SHALL have port Dbg_addr, input, 5, meaning read address for the debug port.
REQ-008 SHALL have port Wr_en, input, 1, meaning write request this cycle.
REQ-009 SHALL have port Wr_addr, input, 5, meaning destination register.
REQ-010 SHALL have port Wr_be, input, 4, meaning byte enables; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have port Wr_data, input, 32, meaning write data.
REQ-012 SHALL have port ALU_DA, output, 32, meaning operand A to the ALU logic and arithmetic units.
REQ-013 SHALL have port ALU_DB, output, 32, meaning operand B to the ALU logic and arithmetic units.
REQ-014 SHALL have port Dbg_data, output, 32, meaning debug read data with no bypass.

Function
REQ-015 SHALL hold NREGS x XLEN storage elements; register 0 SHALL read as 0 always.
REQ-016 SHALL return read data combinationally from the addressed register on ALU_DA, ALU_DB and Dbg_data, with zero added latency.
REQ-017 SHALL write at the rising clk edge when Wr_en=1 and Wr_addr!=0; only bytes with Wr_be[i]=1 update, and the other bytes keep their value.
REQ-018 SHALL ignore writes to register 0, writes with Wr_be=4'b0000, and writes with Wr_en=0.
REQ-019 SHALL bypass on ALU_DA/ALU_DB: when Wr_en=1, Wr_addr!=0 and Wr_addr equals the read address, the output SHALL be the byte-merged value (new bytes where Wr_be=1, stored bytes elsewhere), i.e. the value the register will hold after the edge.
REQ-020 SHALL apply bypass to both operand ports independently when Rs1_addr=Rs2_addr=Wr_addr.
REQ-021 SHALL NOT bypass Dbg_data, which shows stored contents only.
REQ-022 SHALL, for a back-to-back write to the same register, let the later write win at its edge; the bypass SHALL merge against the value stored after the earlier edge.
REQ-023 SHALL require addresses >= NREGS to read 0 and writes to them to be ignored (only reachable when NREGS<32).

Reset
REQ-024 SHALL clear every register to 0 immediately when rst_n=0, independent of clk.
REQ-025 SHALL drive ALU_DA, ALU_DB and Dbg_data to 0 while rst_n=0, including when a bypass condition is present.
REQ-026 SHALL ignore a write whose edge coincides with rst_n=0; the first write accepted is at the first rising edge with rst_n=1.

Structure
REQ-027 SHALL take XLEN, REG_ADDR_W=5, BYTE_W=8 and ZERO_REG=0 from shared package cpu_pkg, which the ALU units also use.
REQ-028 SHALL use one sub-module, byte_merge (inputs: old, new, be; output: merged), instantiated once for the write path and once per bypassed read port.
REQ-029 SHALL contain no other sub-modules; the storage array and bypass compare SHALL be local.

Verification
REQ-030 Reset then read all 32 addresses -> all read 0x00000000 on every port.
REQ-031 Write x5=0xDEADBEEF with be=1111, then read Rs1=5 next cycle -> ALU_DA=0xDEADBEEF; write x0=0xFFFFFFFF -> x0 still reads 0.
REQ-032 With x5=0xDEADBEEF, write 0x11223344 with be=0101 while Rs1=Rs2=5 -> ALU_DA=ALU_DB=0xDE22BE44 in the same cycle, Dbg_data=0xDEADBEEF; after the edge Dbg_data=0xDE22BE44.
REQ-033 Write x7 with Wr_en=1 and be=0000 -> x7 unchanged; bypass output equals the stored value.
REQ-034 Assert rst_n=0 mid-cycle while a write to x3 is pending -> outputs go to 0 immediately, x3=0 after release, and no write occurs at the coincident edge.
REQ-035 Back-to-back writes x9=0xAAAAAAAA (be=1111), then 0x000000BB (be=0001) -> the second-cycle bypass shows 0xAAAAAABB, and x9 holds 0xAAAAAABB afterwards.
